if_stage: RTL

//   Instruction-fetch stage for the 5-stage pipelined RV32I core. Holds the PC,

---
 rtl/riscv_pkg.sv | 9 +
 rtl/pc_reg.sv | 35 +++
 rtl/if_stage.sv | 70 +++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I pipeline.
// Imported by every stage module.
package riscv_pkg;

  localparam int          XLEN          = 32;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection.
// Redirect targets are word-aligned on entry.
module pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc4
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_next;

  assign w_pc4  = r_pc + XLEN'(4);
  assign w_next = i_redirect
                ? (i_redirect_pc & ~XLEN'(3))
                : w_pc4;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_pc <= RESET_PC;
    else if (i_en)
      r_pc <= w_next;
  end

  assign o_pc  = r_pc;
  assign o_pc4 = w_pc4;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, imem address, IF/ID register.
// Redirect squashes the wrong-path fetch held in IF/ID.
module if_stage
  import riscv_pkg::*;
#(
  parameter int                 XLEN     = riscv_pkg::XLEN,
  parameter int                 IMEM_AW  = 6,
  parameter logic [XLEN-1:0]    RESET_PC = XLEN'(RESET_PC_DFLT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic [IMEM_AW-1:0] imem_ra_o,
  input  logic [31:0]        imem_data_i,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    if_id_pc_o,
  output logic [XLEN-1:0]    if_id_pc4_o,
  output logic [31:0]        if_id_instr_o,
  output logic               if_id_valid_o
);

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc4;
  logic            w_pc_en;

  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_pc4;
  logic [31:0]     r_if_instr;
  logic            r_if_valid;

  assign w_pc_en = ~stall_i | redirect_i;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (w_pc_en),
    .i_redirect    (redirect_i),
    .i_redirect_pc (redirect_pc_i),
    .o_pc          (w_pc),
    .o_pc4         (w_pc4)
  );

  assign imem_ra_o = w_pc[IMEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (!rst_n || redirect_i) begin
      r_if_pc    <= '0;
      r_if_pc4   <= '0;
      r_if_instr <= NOP_INSTR;
      r_if_valid <= 1'b0;
    end else if (!stall_i) begin
      r_if_pc    <= w_pc;
      r_if_pc4   <= w_pc4;
      r_if_instr <= imem_data_i;
      r_if_valid <= 1'b1;
    end
  end

  assign pc_o          = w_pc;
  assign if_id_pc_o    = r_if_pc;
  assign if_id_pc4_o   = r_if_pc4;
  assign if_id_instr_o = r_if_instr;
  assign if_id_valid_o = r_if_valid;

endmodule
